// File: rtl/seg7_countdown_monitor.sv
// Display-side monitor for the countdown timer: debounces the sampled display,
// decodes it back to BCD and checks step, cadence and LED consistency.
module seg7_countdown_monitor #(
    parameter int STABLE_CYC   = 4,
    parameter int CNT_W        = 32,
    parameter int MIN_INTERVAL = 4900000,
    parameter int MAX_INTERVAL = 5100000
) (
    input  logic             clk_50M,
    input  logic             rst,
    input  logic             chk_en,
    input  logic             clear,
    input  logic             resync,
    input  logic             dir_up,
    input  logic             hold,
    input  logic [3:0]       tens_bcd,
    input  logic [6:0]       seg_ge,
    input  logic [6:0]       seg_xiao,
    input  logic             led,
    output logic [11:0]      value,
    output logic             value_valid,
    output logic [CNT_W-1:0] interval,
    output logic [15:0]      change_cnt,
    output logic             locked,
    output logic             err_seg,
    output logic             err_step,
    output logic             err_timing,
    output logic             err_led,
    output logic             err_any
);

    localparam int SW = (STABLE_CYC < 1) ? 1 : $clog2(STABLE_CYC + 1);
    localparam logic [SW-1:0]    STAB_MAX = SW'(STABLE_CYC);
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_INTERVAL);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_INTERVAL);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    typedef enum logic {S_IDLE, S_TRACK} state_t;

    // Returns {valid, digit}; anything but the ten legal glyphs is invalid.
    function automatic logic [4:0] f_seg_dec(input logic [6:0] seg);
        case (seg)
            7'h3F:   f_seg_dec = {1'b1, 4'd0};
            7'h06:   f_seg_dec = {1'b1, 4'd1};
            7'h5B:   f_seg_dec = {1'b1, 4'd2};
            7'h4F:   f_seg_dec = {1'b1, 4'd3};
            7'h66:   f_seg_dec = {1'b1, 4'd4};
            7'h6D:   f_seg_dec = {1'b1, 4'd5};
            7'h7D:   f_seg_dec = {1'b1, 4'd6};
            7'h07:   f_seg_dec = {1'b1, 4'd7};
            7'h7F:   f_seg_dec = {1'b1, 4'd8};
            7'h6F:   f_seg_dec = {1'b1, 4'd9};
            default: f_seg_dec = 5'd0;
        endcase
    endfunction

    function automatic logic [9:0] f_bcd2bin(input logic [11:0] bcd);
        f_bcd2bin = 10'(bcd[11:8]) * 10'd100 + 10'(bcd[7:4]) * 10'd10 + 10'(bcd[3:0]);
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [18:0]      r_samp;
    logic [SW-1:0]    r_stab;
    logic [18:0]      r_last;
    logic             r_have_last;
    logic [CNT_W-1:0] r_cnt;
    logic [11:0]      r_value;
    logic             r_value_valid;
    logic [CNT_W-1:0] r_interval;
    logic [15:0]      r_change_cnt;
    logic             r_err_seg, r_err_step, r_err_timing, r_err_led, r_err_any;

    logic [18:0]      w_in;
    logic [4:0]       w_ge_dec, w_xi_dec;
    logic             w_code_ok;
    logic [11:0]      w_new_val;
    logic [9:0]       w_new_bin, w_prev_bin, w_exp_bin;
    logic             w_at_point, w_accept;
    logic             w_locked, w_check;
    logic             w_set_seg, w_set_step, w_set_timing, w_set_led;

    assign w_in       = {tens_bcd, seg_ge, seg_xiao, led};
    assign w_ge_dec   = f_seg_dec(r_samp[14:8]);
    assign w_xi_dec   = f_seg_dec(r_samp[7:1]);
    assign w_code_ok  = (r_samp[18:15] <= 4'd9) & w_ge_dec[4] & w_xi_dec[4];
    assign w_new_val  = {r_samp[18:15], w_ge_dec[3:0], w_xi_dec[3:0]};
    assign w_new_bin  = f_bcd2bin(w_new_val);
    assign w_prev_bin = f_bcd2bin(r_value);
    assign w_exp_bin  = dir_up ? ((w_prev_bin == 10'd999) ? 10'd0 : w_prev_bin + 10'd1)
                               : ((w_prev_bin == 10'd0) ? 10'd999 : w_prev_bin - 10'd1);

    // A stable tuple identical to the last accepted one is never re-reported.
    assign w_at_point = chk_en & (r_stab == STAB_MAX) & (~r_have_last | (r_samp != r_last));
    assign w_accept   = w_at_point & w_code_ok;

    assign w_set_seg    = w_at_point & ~w_code_ok;
    assign w_set_step   = w_accept & w_check & (w_new_bin != w_exp_bin);
    assign w_set_timing = w_accept & w_check &
                          ((r_cnt < MIN_C) | (r_cnt > MAX_C) | (r_cnt == CNT_SAT));
    assign w_set_led    = w_accept & ((w_new_bin == 10'd0) ? ~r_samp[0] : r_samp[0]);

    always_ff @(posedge clk_50M) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_TRACK;
            S_TRACK: if (!chk_en)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_locked = (r_state == S_TRACK);
        w_check  = w_locked & ~resync;
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_samp        <= '0;
            r_stab        <= '0;
            r_last        <= '0;
            r_have_last   <= 1'b0;
            r_cnt         <= '0;
            r_value       <= '0;
            r_value_valid <= 1'b0;
            r_interval    <= '0;
            r_change_cnt  <= '0;
            r_err_seg     <= 1'b0;
            r_err_step    <= 1'b0;
            r_err_timing  <= 1'b0;
            r_err_led     <= 1'b0;
            r_err_any     <= 1'b0;
        end else begin
            r_samp <= w_in;
            if (w_in != r_samp)       r_stab <= '0;
            else if (r_stab != STAB_MAX) r_stab <= r_stab + 1'b1;

            if (!chk_en) begin
                r_have_last <= 1'b0;
            end else if (w_accept) begin
                r_have_last <= 1'b1;
                r_last      <= r_samp;
            end

            if (w_accept)                    r_cnt <= CNT_W'(1);
            else if (!hold && r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;

            r_value_valid <= w_accept;
            if (w_accept) begin
                r_value <= w_new_val;
                if (w_locked) r_interval <= r_cnt;
            end

            // An acceptance coinciding with clear restarts the count at one.
            if (w_accept)
                r_change_cnt <= clear ? 16'd1 :
                                (r_change_cnt == 16'hFFFF) ? r_change_cnt : r_change_cnt + 16'd1;
            else if (clear)
                r_change_cnt <= 16'd0;

            r_err_seg    <= (r_err_seg    & ~clear) | w_set_seg;
            r_err_step   <= (r_err_step   & ~clear) | w_set_step;
            r_err_timing <= (r_err_timing & ~clear) | w_set_timing;
            r_err_led    <= (r_err_led    & ~clear) | w_set_led;
            r_err_any    <= r_err_seg | r_err_step | r_err_timing | r_err_led;
        end
    end

    assign value       = r_value;
    assign value_valid = r_value_valid;
    assign interval    = r_interval;
    assign change_cnt  = r_change_cnt;
    assign locked      = w_locked;
    assign err_seg     = r_err_seg;
    assign err_step    = r_err_step;
    assign err_timing  = r_err_timing;
    assign err_led     = r_err_led;
    assign err_any     = r_err_any;

endmodule

// File: doc/seg7_countdown_monitor.md
Name: seg7_countdown_monitor

Overview:
- Receiving end of the countdown timer's display interface: samples the tens BCD digit, the two 7-segment digit buses (ones, tenths) and the done LED.
- Debounces the captured display tuple, decodes it back to BCD and reports each new displayed value with the cycle interval since the previous one.
- Checks step, cadence and LED consistency, with sticky error flags. Used on board as a self-check and in benches as the display scoreboard.

Parameters:
STABLE_CYC, 4, consecutive identical samples needed before a tuple is accepted (>=1)
CNT_W, 32, width of interval counter/output
MIN_INTERVAL, 4900000, smallest legal interval between accepted values (cycles)
MAX_INTERVAL, 5100000, largest legal interval between accepted values (cycles)

Ports:
clk_50M  in  1  system clock
rst  in  1  synchronous, active-high reset
chk_en  in  1  monitor enable; low forces IDLE, nothing accepted
clear  in  1  clears sticky errors and change_cnt
resync  in  1  next acceptance is not step/interval checked
dir_up  in  1  1 = expect +1 steps, 0 = expect -1 steps
hold  in  1  freezes interval counter (timer paused)
tens_bcd  in  4  tens digit, BCD
seg_ge  in  7  ones digit segments {g,f,e,d,c,b,a}, active-high
seg_xiao  in  7  tenths digit segments, same encoding
led  in  1  timer done indicator
value  out  12  accepted value {tens,ones,tenths} BCD
value_valid  out  1  one-cycle pulse on acceptance
interval  out  CNT_W  non-hold cycles between last two acceptances
change_cnt  out  16  number of acceptances, saturating
locked  out  1  high in TRACK state
err_seg, err_step, err_timing, err_led  out  1 each  sticky error flags
err_any  out  1  registered OR of the four sticky flags

Behaviour:
- Reset: all outputs 0; state IDLE; sample and stability registers 0.
- Segment decode: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. Any other code, or tens_bcd>9, is invalid.
- Sampling: inputs registered once each cycle into sample register S. stab_cnt resets to 0 when S changes, otherwise increments, saturating at STABLE_CYC.
- Acceptance: occurs when S has been identical for STABLE_CYC consecutive cycles, chk_en=1, and S differs from the last accepted tuple (or nothing has been accepted since IDLE).
  - Timing: value_valid pulses STABLE_CYC+1 cycles after the input change.
  - The same tuple is never accepted twice in a row.
- Invalid code at the acceptance point: err_seg set, no acceptance, value unchanged.
- FSM IDLE -> TRACK: first valid acceptance with chk_en=1. value, value_valid and change_cnt update. No step, interval or LED-timing checks.
- FSM TRACK -> TRACK: each acceptance updates value, interval, value_valid and change_cnt.
  - Step check: expected value is previous ±1 in decimal on the 3-digit value. Wrap: 999+1 -> 000 and 000-1 -> 999. Mismatch sets err_step.
  - Interval check: interval < MIN_INTERVAL or > MAX_INTERVAL sets err_timing.
- LED check, every acceptance (IDLE and TRACK): accepted value==000 with led=0, or value!=000 with led=1, sets err_led.
- resync: when high at acceptance, step and interval checks are skipped for that acceptance; the state stays TRACK.
- FSM TRACK -> IDLE: chk_en=0. The last accepted tuple is forgotten; value is held.
- Interval counter:
  - Cleared to 1 on the acceptance cycle.
  - Otherwise increments each cycle with hold=0; held when hold=1.
  - Saturates at all-ones, and a saturated count is a timing error.
  - interval output shows the counter value present at acceptance.
- Priority: rst > set-error > clear. An error raised in the same cycle as clear remains set. change_cnt is cleared by clear, but an acceptance in that cycle loads 1.
- err_any lags the sticky flags by one cycle.
- Reset mid-operation returns to IDLE regardless of stab_cnt or counter contents.

Test Plan:
1. Reset, chk_en=1, STABLE_CYC=4. Drive 1/9(6F)/9(6F), led=0 -> value_valid exactly 5 cycles later, value=12'h199, locked=1, no errors.
2. MIN/MAX=10/10, dir_up=0. Step 199 -> 198 -> 197 every 10 cycles -> interval=10 each time, change_cnt=3, err_step=err_timing=0. A 12-cycle gap -> err_timing=1.
3. Step 197 -> 195 -> err_step=1, err_any=1 one cycle later. clear pulse -> all flags 0, change_cnt=0.
4. A 2-cycle glitch of seg_ge=06 inside a stable 7F period -> no value_valid. An invalid code 7'h01 held 6 cycles -> err_seg=1, value unchanged.
5. Reach 000 with led=1 -> no error. 001 with led=1 -> err_led=1. hold=1 for 20 of 30 cycles between acceptances -> interval=10.
6. resync=1 with a jump 000 -> 199 -> no err_step or err_timing. chk_en=0 -> locked=0. rst asserted mid-stability window -> all outputs 0 next cycle.
